// File: rtl/gat_feat_bram_reader_pkg.sv
// Shared GAT constants and the state type for the feature BRAM streamer.
package gat_feat_bram_reader_pkg;

  localparam int NUM_SUBGRAPHS     = 2708;
  localparam int NUM_FEATURE_OUT   = 16;
  localparam int NEW_FEATURE_WIDTH = 32;
  localparam int NEW_FEATURE_DEPTH = NUM_SUBGRAPHS * NUM_FEATURE_OUT;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_t;

endpackage

// File: rtl/gat_feat_bram_reader_sync_fifo.sv
// Small show-ahead synchronous FIFO; rd_data always presents the head entry.
module gat_sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_en,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic             i_rd_en,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_empty,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_wr;
  logic             w_rd;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_wr = i_wr_en && (r_count != CNT_W'(DEPTH));
  assign w_rd = i_rd_en && (r_count != '0);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_rd) r_rd_ptr <= ptr_inc(r_rd_ptr);
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wr_data;
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

endmodule

// File: rtl/gat_feat_bram_reader.sv
// Streams the first N words of the feature BRAM out over AXI-Stream,
// throttling address issue so every returned word has a FIFO slot.
//   state    | meaning
//   ST_IDLE  | waiting for start; word 0 is issued on the accepting edge
//   ST_READ  | issuing addresses while FIFO space allows
//   ST_DRAIN | all addresses issued; waiting for the tlast handshake
module gat_feat_bram_reader #(
  parameter int NEW_FEATURE_WIDTH  = gat_feat_bram_reader_pkg::NEW_FEATURE_WIDTH,
  parameter int NEW_FEATURE_DEPTH  = gat_feat_bram_reader_pkg::NEW_FEATURE_DEPTH,
  parameter int NEW_FEATURE_ADDR_W = $clog2(NEW_FEATURE_DEPTH),
  parameter int BRAM_RD_LATENCY    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [NEW_FEATURE_ADDR_W:0]   num_words,
  output logic [NEW_FEATURE_ADDR_W+1:0] feat_bram_addrb,
  input  logic [NEW_FEATURE_WIDTH-1:0]  feat_bram_dout,
  output logic [NEW_FEATURE_WIDTH-1:0]  m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic                          m_axis_tlast,
  output logic                          busy,
  output logic                          done
);

  import gat_feat_bram_reader_pkg::*;

  localparam int FIFO_DEPTH = BRAM_RD_LATENCY + 2;
  localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam int N_W        = NEW_FEATURE_ADDR_W + 1;
  localparam logic [N_W-1:0] DEPTH_N = N_W'(NEW_FEATURE_DEPTH);

  rd_state_t r_state;
  rd_state_t w_state_nxt;

  logic [N_W-1:0]                  r_n;
  logic [N_W-1:0]                  r_idx;
  logic [N_W-1:0]                  r_out_idx;
  logic [NEW_FEATURE_ADDR_W+1:0]   r_addrb;
  logic                            r_rd_live;
  logic [BRAM_RD_LATENCY-1:0]      r_vpipe;
  logic                            r_done;

  logic [N_W-1:0]                  w_n_clamped;
  logic [N_W-1:0]                  w_issue_idx;
  logic                            w_issue;
  logic                            w_pop;
  logic                            w_room;
  logic [CNT_W-1:0]                w_inflight;
  logic [CNT_W:0]                  w_reserved;
  logic                            w_fifo_empty;
  logic [CNT_W-1:0]                w_fifo_count;
  logic [NEW_FEATURE_WIDTH-1:0]    w_fifo_data;

  assign w_n_clamped = (num_words > DEPTH_N) ? DEPTH_N : num_words;
  assign w_pop       = m_axis_tvalid && m_axis_tready;

  // A slot is reserved from issue until pop; a pop this cycle frees one.
  always_comb begin
    w_inflight = CNT_W'(r_rd_live);
    for (int k = 0; k < BRAM_RD_LATENCY; k++) begin
      w_inflight = w_inflight + CNT_W'(r_vpipe[k]);
    end
    w_reserved = {1'b0, w_fifo_count} + {1'b0, w_inflight} - (CNT_W + 1)'(w_pop);
  end

  assign w_room = (w_reserved < (CNT_W + 1)'(FIFO_DEPTH));

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_issue_idx = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (start && (w_n_clamped != '0)) begin
          w_state_nxt = ST_READ;
          w_issue     = 1'b1;
          w_issue_idx = '0;
        end
      end
      ST_READ: begin
        if ((r_idx < r_n) && w_room) w_issue = 1'b1;
        if ((r_idx == r_n) || (w_issue && (r_idx == r_n - 1'b1))) w_state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop && m_axis_tlast) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_n       <= '0;
      r_idx     <= '0;
      r_out_idx <= '0;
      r_addrb   <= '0;
      r_rd_live <= 1'b0;
      r_vpipe   <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_rd_live <= w_issue;
      r_vpipe[0] <= r_rd_live;
      for (int k = 1; k < BRAM_RD_LATENCY; k++) begin
        r_vpipe[k] <= r_vpipe[k-1];
      end
      if (w_issue) begin
        r_addrb <= {w_issue_idx[NEW_FEATURE_ADDR_W-1:0], 2'b00};
        r_idx   <= w_issue_idx + 1'b1;
      end
      if ((r_state == ST_IDLE) && start) begin
        r_n       <= w_n_clamped;
        r_out_idx <= '0;
      end else if (w_pop) begin
        r_out_idx <= r_out_idx + 1'b1;
      end
      r_done <= ((r_state == ST_IDLE) && start && (w_n_clamped == '0)) ||
                ((r_state == ST_DRAIN) && w_pop && m_axis_tlast);
    end
  end

  gat_sync_fifo #(
    .WIDTH (NEW_FEATURE_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .CNT_W (CNT_W)
  ) u_out_fifo (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_wr_en   (r_vpipe[BRAM_RD_LATENCY-1]),
    .i_wr_data (feat_bram_dout),
    .i_rd_en   (w_pop),
    .o_rd_data (w_fifo_data),
    .o_empty   (w_fifo_empty),
    .o_count   (w_fifo_count)
  );

  assign m_axis_tvalid   = !w_fifo_empty;
  assign m_axis_tdata    = m_axis_tvalid ? w_fifo_data : '0;
  assign m_axis_tlast    = m_axis_tvalid && (r_out_idx == r_n - 1'b1);
  assign feat_bram_addrb = r_addrb;
  assign busy            = (r_state != ST_IDLE);
  assign done            = r_done;

endmodule

// File: tb/tb_gat_feat_bram_reader.sv
// Bench for gat_feat_bram_reader: BRAM model with fixed read latency and a
// list-of-words reference model of the expected stream.
module tb_gat_feat_bram_reader;

  localparam int W     = 32;
  localparam int DEPTH = 43328;
  localparam int AW    = $clog2(DEPTH);
  localparam int LAT   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num_words;
  logic [AW+1:0] addrb;
  logic [W-1:0]  dout;
  logic [W-1:0]  tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          busy;
  logic          done;

  gat_feat_bram_reader #(
    .NEW_FEATURE_WIDTH  (W),
    .NEW_FEATURE_DEPTH  (DEPTH),
    .NEW_FEATURE_ADDR_W (AW),
    .BRAM_RD_LATENCY    (LAT)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_words       (num_words),
    .feat_bram_addrb (addrb),
    .feat_bram_dout  (dout),
    .m_axis_tdata    (tdata),
    .m_axis_tvalid   (tvalid),
    .m_axis_tready   (tready),
    .m_axis_tlast    (tlast),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] seed;

  function automatic logic [31:0] fdata(input int idx);
    return (32'(idx) * 32'h9E3779B1) ^ seed;
  endfunction

  // BRAM: address seen in one cycle gives data LAT cycles later
  logic [W-1:0] bram_pipe [LAT];
  always @(posedge clk) begin
    bram_pipe[0] <= fdata(int'(addrb[AW+1:2]));
    for (int k = 1; k < LAT; k++) bram_pipe[k] <= bram_pipe[k-1];
  end
  assign dout = bram_pipe[LAT-1];

  logic [31:0] got_data[$];
  bit          got_last[$];
  int          got_cyc[$];
  int          done_cyc[$];
  logic [31:0] exp_data[$];
  bit          exp_last[$];
  int          first_vld;
  int          max_addr;
  int          stab_viol;
  bit          prev_stall;
  logic [31:0] prev_data;
  logic        prev_last;
  int          s_cyc;
  int          n_checks = 0;
  int          n_pass = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stab_viol++;
      prev_stall = tvalid && !tready;
      prev_data  = tdata;
      prev_last  = tlast;
      if (tvalid && first_vld < 0) first_vld = cyc;
      if (tvalid && tready) begin
        got_data.push_back(tdata);
        got_last.push_back(tlast);
        got_cyc.push_back(cyc);
      end
      if (done) done_cyc.push_back(cyc);
      if (int'(addrb) > max_addr) max_addr = int'(addrb);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_data.delete(); got_last.delete(); got_cyc.delete(); done_cyc.delete();
    exp_data.delete(); exp_last.delete();
    first_vld = -1;
    stab_viol = 0;
  endtask

  task automatic pulse_start(input int n);
    start     = 1'b1;
    num_words = (AW+1)'(n);
    s_cyc     = cyc;
    tick();
    start     = 1'b0;
    max_addr  = -1;
  endtask

  // Expected stream: words 0..min(n,DEPTH)-1, tlast on the final one
  task automatic model_xfer(input int n);
    int n_eff;
    n_eff = (n > DEPTH) ? DEPTH : n;
    for (int i = 0; i < n_eff; i++) begin
      exp_data.push_back(fdata(i));
      exp_last.push_back(i == n_eff - 1);
    end
  endtask

  function automatic int diff_errs();
    int e = 0;
    int m;
    m = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
    if (got_data.size() != exp_data.size()) e++;
    for (int i = 0; i < m; i++) begin
      if (got_data[i] !== exp_data[i] || got_last[i] !== exp_last[i]) e++;
    end
    return e;
  endfunction

  task automatic drive_ready(input int mode);
    if (mode == 1) tready = !tready;
    else if (mode == 2) tready = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_done(input int mode, input int ndone, input int budget, output bit to);
    to = 1'b1;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc.size() >= ndone) break;
      drive_ready(mode);
      tick();
    end
    if (done_cyc.size() >= ndone) to = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; num_words = '0; tready = 1'b0;
    repeat (3) tick();
    n_checks++; if (tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", tvalid); else n_pass++;
    n_checks++; if (tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", tlast); else n_pass++;
    n_checks++; if (tdata !== '0) $display("FAIL rst_tdata: got %h want 0", tdata); else n_pass++;
    n_checks++; if (addrb !== '0) $display("FAIL rst_addrb: got %h want 0", addrb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b want 0", busy); else n_pass++;
    n_checks++; if (done !== 1'b0) $display("FAIL rst_done: got %b want 0", done); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bit to;
    int last_c;
    clear_mon();
    tready = 1'b1;
    pulse_start(16);
    model_xfer(16);
    n_checks++; if (busy !== 1'b1) $display("FAIL basic_busy: got %b want 1", busy); else n_pass++;
    wait_done(0, 1, 200, to);
    last_c = (got_cyc.size() > 0) ? got_cyc[got_cyc.size()-1] : -100;
    n_checks++; if (to) $display("FAIL basic_timeout: got no done want done"); else n_pass++;
    n_checks++; if (got_data.size() != 16) $display("FAIL basic_count: got %0d want 16", got_data.size()); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL basic_data: got %0d errors want 0", diff_errs()); else n_pass++;
    n_checks++; if (first_vld != s_cyc + LAT + 2) $display("FAIL basic_first_valid: got cycle %0d want %0d", first_vld - s_cyc, LAT + 2); else n_pass++;
    n_checks++; if (got_cyc.size() == 16 && last_c - got_cyc[0] != 15) $display("FAIL basic_rate: got span %0d want 15", last_c - got_cyc[0]); else n_pass++;
    n_checks++; if (done_cyc.size() < 1 || done_cyc[0] != last_c + 1) $display("FAIL basic_done_cycle: got %0d want %0d", (done_cyc.size() > 0) ? done_cyc[0] : -1, last_c + 1); else n_pass++;
    n_checks++; if (max_addr != 60) $display("FAIL basic_max_addr: got %0d want 60", max_addr); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_toggle();
    bit to;
    clear_mon();
    tready = 1'b1;
    pulse_start(16);
    model_xfer(16);
    wait_done(1, 1, 400, to);
    n_checks++; if (to) $display("FAIL toggle_timeout: got no done want done"); else n_pass++;
    n_checks++; if (got_data.size() != 16) $display("FAIL toggle_count: got %0d want 16", got_data.size()); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL toggle_data: got %0d errors want 0", diff_errs()); else n_pass++;
    n_checks++; if (max_addr != 60) $display("FAIL toggle_max_addr: got %0d want 60", max_addr); else n_pass++;
    n_checks++; if (stab_viol != 0) $display("FAIL toggle_stable: got %0d violations want 0", stab_viol); else n_pass++;
  endtask

  task automatic test_stall();
    bit to;
    clear_mon();
    tready = 1'b0;
    pulse_start(16);
    model_xfer(16);
    repeat (20) tick();
    n_checks++; if (!(max_addr <= 12)) $display("FAIL stall_addr_limit: got %0d want <= 12", max_addr); else n_pass++;
    n_checks++; if (tvalid !== 1'b1) $display("FAIL stall_tvalid: got %b want 1", tvalid); else n_pass++;
    n_checks++; if (tdata !== fdata(0)) $display("FAIL stall_tdata: got %h want %h", tdata, fdata(0)); else n_pass++;
    n_checks++; if (tlast !== 1'b0) $display("FAIL stall_tlast: got %b want 0", tlast); else n_pass++;
    tready = 1'b1;
    wait_done(0, 1, 200, to);
    n_checks++; if (to) $display("FAIL stall_timeout: got no done want done"); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL stall_data: got %0d errors want 0", diff_errs()); else n_pass++;
    n_checks++; if (stab_viol != 0) $display("FAIL stall_stable: got %0d violations want 0", stab_viol); else n_pass++;
  endtask

  task automatic test_zero_and_clamp();
    bit to;
    clear_mon();
    tready = 1'b1;
    pulse_start(0);
    n_checks++; if (done !== 1'b1) $display("FAIL zero_done: got %b want 1", done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL zero_busy: got %b want 0", busy); else n_pass++;
    repeat (6) tick();
    n_checks++; if (first_vld != -1) $display("FAIL zero_no_valid: got first valid %0d want none", first_vld); else n_pass++;
    n_checks++; if (done_cyc.size() != 1 || done_cyc[0] != s_cyc + 1) $display("FAIL zero_done_cycle: got %0d pulses want 1 at +1", done_cyc.size()); else n_pass++;

    clear_mon();
    pulse_start(50000);
    model_xfer(50000);
    wait_done(0, 1, 44000, to);
    n_checks++; if (to) $display("FAIL clamp_timeout: got no done want done"); else n_pass++;
    n_checks++; if (got_data.size() != DEPTH) $display("FAIL clamp_count: got %0d want %0d", got_data.size(), DEPTH); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL clamp_data: got %0d errors want 0", diff_errs()); else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit to;
    clear_mon();
    tready = 1'b1;
    pulse_start(16);
    for (int i = 0; i < 100; i++) begin
      if (got_data.size() >= 7) break;
      tick();
    end
    n_checks++; if (got_data.size() < 7) $display("FAIL rmid_reach7: got %0d beats want 7", got_data.size()); else n_pass++;
    rst = 1'b1;
    tick();
    n_checks++; if (tvalid !== 1'b0) $display("FAIL rmid_tvalid: got %b want 0", tvalid); else n_pass++;
    n_checks++; if (tlast !== 1'b0) $display("FAIL rmid_tlast: got %b want 0", tlast); else n_pass++;
    n_checks++; if (tdata !== '0) $display("FAIL rmid_tdata: got %h want 0", tdata); else n_pass++;
    n_checks++; if (addrb !== '0) $display("FAIL rmid_addrb: got %h want 0", addrb); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rmid_busy: got %b want 0", busy); else n_pass++;
    rst = 1'b0;
    repeat (3) tick();
    n_checks++; if (tvalid !== 1'b0) $display("FAIL rmid_stale: got tvalid %b want 0", tvalid); else n_pass++;
    clear_mon();
    pulse_start(16);
    model_xfer(16);
    wait_done(0, 1, 200, to);
    n_checks++; if (to) $display("FAIL rmid_timeout: got no done want done"); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL rmid_restart_data: got %0d errors want 0", diff_errs()); else n_pass++;
  endtask

  task automatic test_back_to_back();
    bit to;
    int n1;
    int n2;
    clear_mon();
    tready = 1'b1;
    pulse_start(16);
    model_xfer(16);
    repeat (3) tick();
    n_checks++; if (busy !== 1'b1) $display("FAIL busy_mid: got %b want 1", busy); else n_pass++;
    start = 1'b1; num_words = (AW+1)'(5);
    tick();
    start = 1'b0;
    wait_done(0, 1, 200, to);
    repeat (12) tick();
    n_checks++; if (to) $display("FAIL ignore_timeout: got no done want done"); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL ignore_data: got %0d errors want 0", diff_errs()); else n_pass++;
    n_checks++; if (done_cyc.size() != 1) $display("FAIL ignore_done_count: got %0d want 1", done_cyc.size()); else n_pass++;

    clear_mon();
    n1 = $urandom_range(1, 20);
    n2 = $urandom_range(1, 20);
    pulse_start(n1);
    model_xfer(n1);
    model_xfer(n2);
    for (int i = 0; i < 200; i++) begin
      if (done === 1'b1) break;
      tick();
    end
    n_checks++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b want 1", done); else n_pass++;
    start = 1'b1; num_words = (AW+1)'(n2);
    tick();
    start = 1'b0;
    wait_done(0, 2, 200, to);
    n_checks++; if (to) $display("FAIL b2b_timeout: got %0d dones want 2", done_cyc.size()); else n_pass++;
    n_checks++; if (got_data.size() != n1 + n2) $display("FAIL b2b_count: got %0d want %0d", got_data.size(), n1 + n2); else n_pass++;
    n_checks++; if (diff_errs() != 0) $display("FAIL b2b_data: got %0d errors want 0", diff_errs()); else n_pass++;
  endtask

  task automatic test_random();
    bit to;
    int n;
    for (int it = 0; it < 4; it++) begin
      clear_mon();
      n = $urandom_range(1, 40);
      tready = 1'b1;
      pulse_start(n);
      model_xfer(n);
      wait_done(2, 1, 2000, to);
      n_checks++; if (to) $display("FAIL rand%0d_timeout: got no done want done (n=%0d)", it, n); else n_pass++;
      n_checks++; if (diff_errs() != 0) $display("FAIL rand%0d_data: got %0d errors want 0 (n=%0d)", it, diff_errs(), n); else n_pass++;
      n_checks++; if (stab_viol != 0) $display("FAIL rand%0d_stable: got %0d violations want 0", it, stab_viol); else n_pass++;
    end
  endtask

  initial begin
    seed = $urandom;
    first_vld = -1;
    max_addr = -1;
    stab_viol = 0;
    test_reset();
    test_basic();
    test_toggle();
    test_stall();
    test_zero_and_clamp();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit reached");
  end

endmodule

// File: doc/gat_feat_bram_reader.md
GAT_FEAT_BRAM_READER -- requirements
Module: gat_feat_bram_reader

Interface
REQ-001 SHALL have parameter NEW_FEATURE_WIDTH, default 32: width of one output-feature word.
REQ-002 SHALL have parameter NEW_FEATURE_DEPTH, default 43328 (2708 subgraphs x 16 features): number of words in the feature BRAM.
REQ-003 SHALL have parameter NEW_FEATURE_ADDR_W, default $clog2(NEW_FEATURE_DEPTH): word-address width.
REQ-004 SHALL have parameter BRAM_RD_LATENCY, default 2: cycles from addrb change to valid dout (range 1..3).
REQ-005 SHALL have port clk, input, 1: single clock for all logic.
REQ-006 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-007 SHALL have port start, input, 1: one-cycle request to stream the feature BRAM out.
REQ-008 SHALL have port num_words, input, NEW_FEATURE_ADDR_W+1: number of words to stream, sampled with start.
REQ-009 SHALL have port feat_bram_addrb, output, NEW_FEATURE_ADDR_W+2: byte address to the feature BRAM, bits [1:0] always 0.
REQ-010 SHALL have port feat_bram_dout, input, NEW_FEATURE_WIDTH: BRAM read data.
REQ-011 SHALL have ports m_axis_tdata (output, NEW_FEATURE_WIDTH), m_axis_tvalid (output, 1), m_axis_tready (input, 1), m_axis_tlast (output, 1): AXI-Stream master.
REQ-012 SHALL have ports busy (output, 1: transfer in progress) and done (output, 1: one-cycle completion pulse).

Function
REQ-013 SHALL implement FSM IDLE -> READ -> DRAIN -> IDLE; IDLE->READ on start with num_words>0; READ->DRAIN after the last address is issued; DRAIN->IDLE on the handshake of the word carrying tlast.
REQ-014 SHALL, on start with num_words==0, stay in IDLE, emit no beats, and pulse done the next cycle.
REQ-015 SHALL clamp num_words greater than NEW_FEATURE_DEPTH to NEW_FEATURE_DEPTH.
REQ-016 SHALL ignore start while busy is high.
REQ-017 SHALL drive feat_bram_addrb = word_index x 4, word_index counting 0..N-1, and hold its last value when not issuing.
REQ-018 SHALL track issued-but-unreturned reads in a BRAM_RD_LATENCY-deep valid shift pipeline and capture dout into an output FIFO of depth BRAM_RD_LATENCY+2 when the pipeline tail is valid.
REQ-019 SHALL issue a new address only when FIFO occupancy plus in-flight reads is less than FIFO depth, so no returned word is ever dropped.
REQ-020 SHALL, with m_axis_tready held high, assert the first tvalid exactly BRAM_RD_LATENCY+2 cycles after the start cycle and sustain one beat per cycle thereafter.
REQ-021 SHALL hold tdata/tlast stable while tvalid is high and tready is low.
REQ-022 SHALL assert tlast only with word N-1.
REQ-023 SHALL assert busy from the cycle after an accepted start until the cycle of the final handshake, and pulse done on the cycle after it.
REQ-024 SHALL allow a new start in the same cycle that done is high.

Reset
REQ-025 SHALL, on rst, clear FSM to IDLE, counters, pipeline valids and FIFO pointers; outputs SHALL be tvalid=0, tlast=0, tdata=0, addrb=0, busy=0, done=0.
REQ-026 SHALL, on rst asserted mid-transfer, discard all in-flight reads and buffered words with no beat emitted in the following cycle.

Structure
REQ-027 SHALL take default depth and width constants from the shared GAT package (NUM_SUBGRAPHS, NUM_FEATURE_OUT, NEW_FEATURE_WIDTH) and define the FSM state enum there.
REQ-028 SHALL instantiate one sub-module, gat_sync_fifo, for the output buffer; all other logic is local.

Verification
REQ-029 SHALL cover: start, num_words=16, tready=1 -> 16 beats at addrb 0x00..0x3C, first tvalid at cycle 4 (LAT=2), tlast on beat 16, done one cycle later.
REQ-030 SHALL cover: num_words=16 with tready toggling 1/0 every cycle -> 16 beats, data in order, no loss/duplication, addrb never exceeds 0x3C.
REQ-031 SHALL cover: tready=0 for 20 cycles after start -> at most 4 addresses issued, tvalid held with word 0 stable, then all words stream after release.
REQ-032 SHALL cover: num_words=0 -> no tvalid, done pulsed one cycle after start; num_words=50000 -> exactly 43328 beats.
REQ-033 SHALL cover: rst at beat 7 of 16 -> outputs at reset values next cycle; fresh start streams from word 0.
REQ-034 SHALL cover: start pulsed while busy -> ignored; back-to-back start on done cycle -> second transfer completes correctly.
